// File: rtl/vtiming.sv
// Vertical timing stage: counts lines on falling edges of the horizontal
// active flag and produces row, vactive/vsync, frame markers and a registered pixel stream.
module vtiming #(
    parameter int unsigned VACTIVE      = 272,
    parameter int unsigned VFRONT_PORCH = 2,
    parameter int unsigned VSYNC_LEN    = 10,
    parameter int unsigned VBACK_PORCH  = 2
) (
    input  logic       pxclk_i,
    input  logic       rstn_i,
    input  logic       hactive_i,
    input  logic [8:0] col_i,
    output logic [8:0] row_o,
    output logic       vactive_o,
    output logic       vsync_o,
    output logic       frame_start_o,
    output logic [7:0] frame_cnt_o,
    output logic       de_o,
    output logic [8:0] pix_x_o,
    output logic [8:0] pix_y_o
);

    localparam int unsigned VTOTAL   = VACTIVE + VFRONT_PORCH + VSYNC_LEN + VBACK_PORCH;
    localparam logic [8:0]  MAXROW   = 9'(VTOTAL - 1);
    localparam logic [8:0]  VACT_END = 9'(VACTIVE);
    localparam logic [8:0]  VS_START = 9'(VACTIVE + VFRONT_PORCH);
    localparam logic [8:0]  VS_END   = 9'(VACTIVE + VFRONT_PORCH + VSYNC_LEN);

    logic       hact_q,        hact_d;
    logic [8:0] row_q,         row_d;
    logic       vactive_q,     vactive_d;
    logic       vsync_q,       vsync_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_cnt_q,   frame_cnt_d;
    logic       de_q,          de_d;
    logic [8:0] pix_x_q,       pix_x_d;
    logic [8:0] pix_y_q,       pix_y_d;
    logic       line_end;

    always_comb begin
        hact_d        = hactive_i;
        line_end      = hact_q & ~hactive_i;
        row_d         = row_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        if (line_end) begin
            if (row_q == MAXROW) begin
                row_d         = '0;
                frame_start_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + 8'd1;
            end else begin
                row_d = row_q + 9'd1;
            end
        end

        // Decoded from the next row so the flags move in lockstep with row_o.
        vactive_d = (row_d < VACT_END);
        vsync_d   = ~((row_d >= VS_START) && (row_d < VS_END));

        de_d    = hactive_i & vactive_q;
        pix_x_d = col_i;
        pix_y_d = row_q;
    end

    always_ff @(posedge pxclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hact_q        <= 1'b0;
            row_q         <= '0;
            vactive_q     <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            de_q          <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
        end else begin
            hact_q        <= hact_d;
            row_q         <= row_d;
            vactive_q     <= vactive_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            de_q          <= de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
        end
    end

    assign row_o         = row_q;
    assign vactive_o     = vactive_q;
    assign vsync_o       = vsync_q;
    assign frame_start_o = frame_start_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign de_o          = de_q;
    assign pix_x_o       = pix_x_q;
    assign pix_y_o       = pix_y_q;

endmodule

// File: tb/tb_vtiming.sv
// Bench for vtiming: a default-timing instance plus a tiny-frame instance,
// both compared against a line-count based reference model.
module tb_vtiming;

    logic       pxclk = 1'b0;
    logic       rstn;
    logic       hact;
    logic [8:0] col;

    logic [8:0] row0, px0, py0, row1, px1, py1;
    logic       vact0, vs0, fs0, de0, vact1, vs1, fs1, de1;
    logic [7:0] fc0, fc1;
    logic [38:0] dv [2];

    int checks   = 0;
    int failures = 0;

    always #5 pxclk = ~pxclk;

    vtiming dut (
        .pxclk_i(pxclk), .rstn_i(rstn), .hactive_i(hact), .col_i(col),
        .row_o(row0), .vactive_o(vact0), .vsync_o(vs0), .frame_start_o(fs0),
        .frame_cnt_o(fc0), .de_o(de0), .pix_x_o(px0), .pix_y_o(py0)
    );

    vtiming #(.VACTIVE(4), .VFRONT_PORCH(1), .VSYNC_LEN(2), .VBACK_PORCH(1)) dut_small (
        .pxclk_i(pxclk), .rstn_i(rstn), .hactive_i(hact), .col_i(col),
        .row_o(row1), .vactive_o(vact1), .vsync_o(vs1), .frame_start_o(fs1),
        .frame_cnt_o(fc1), .de_o(de1), .pix_x_o(px1), .pix_y_o(py1)
    );

    assign dv[0] = {row0, vact0, vs0, fs0, fc0, de0, px0, py0};
    assign dv[1] = {row1, vact1, vs1, fs1, fc1, de1, px1, py1};

    // Reference model: everything follows from the number of line ends seen.
    int         m_lines;
    logic       m_prevh;
    logic [8:0] e_row [2];
    logic       e_vact [2], e_vs [2], e_fs [2], e_de [2];
    logic [7:0] e_fc [2];
    logic [8:0] e_px [2], e_py [2];

    function automatic int va(int k); return (k == 0) ? 272 : 4; endfunction
    function automatic int fp(int k); return (k == 0) ? 2 : 1;   endfunction
    function automatic int sl(int k); return (k == 0) ? 10 : 2;  endfunction
    function automatic int bp(int k); return (k == 0) ? 2 : 1;   endfunction
    function automatic int vt(int k); return va(k) + fp(k) + sl(k) + bp(k); endfunction

    task automatic model_reset();
        m_lines = 0;
        m_prevh = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e_row[k] = '0; e_vact[k] = 1'b1; e_vs[k] = 1'b1; e_fs[k] = 1'b0;
            e_fc[k] = '0; e_de[k] = 1'b0; e_px[k] = '0; e_py[k] = '0;
        end
    endtask

    task automatic model_step(input logic h, input logic [8:0] c);
        bit fall;
        fall    = m_prevh && !h;
        m_prevh = h;
        if (fall) m_lines++;
        for (int k = 0; k < 2; k++) begin
            int r;
            logic old_vact;
            logic [8:0] old_row;
            old_vact  = e_vact[k];
            old_row   = e_row[k];
            r         = m_lines % vt(k);
            e_fs[k]   = fall && (r == 0);
            e_row[k]  = 9'(r);
            e_fc[k]   = 8'((m_lines / vt(k)) % 256);
            e_vact[k] = (r < va(k));
            e_vs[k]   = !((r >= va(k) + fp(k)) && (r < va(k) + fp(k) + sl(k)));
            e_de[k]   = h && old_vact;
            e_px[k]   = c;
            e_py[k]   = old_row;
        end
    endtask

    function automatic logic [38:0] expv(int k);
        return {e_row[k], e_vact[k], e_vs[k], e_fs[k], e_fc[k], e_de[k], e_px[k], e_py[k]};
    endfunction

    // Pixel coordinates are only meaningful while de is expected high.
    function automatic logic [38:0] msk(int k);
        return e_de[k] ? '1 : {21'h1FFFFF, 18'h0};
    endfunction

    task automatic cyc(input logic h, input logic [8:0] c);
        hact = h;
        col  = c;
        @(posedge pxclk);
        if (rstn) model_step(h, c);
        else      model_reset();
        @(negedge pxclk);
    endtask

    task automatic run_line(input int hi, input int lo);
        for (int i = 0; i < hi; i++) cyc(1'b1, 9'(i));
        for (int i = 0; i < lo; i++) cyc(1'b0, 9'd0);
    endtask

    task automatic rand_line();
        run_line(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
    endtask

    task automatic test_reset();
        rstn = 1'b0; hact = 1'b0; col = '0;
        model_reset();
        repeat (3) cyc(1'b0, 9'd0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dv[k] !== 39'({9'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 9'd0, 9'd0})) begin
                failures++;
                $display("FAIL reset_state inst%0d got=%h exp=%h", k, dv[k],
                         {9'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 9'd0, 9'd0});
            end
        end
        hact = 1'b1;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 9'(i));
            checks++;
            if (row0 !== 9'd0) begin
                failures++;
                $display("FAIL reset_release_hold got=%0d exp=0", row0);
            end
        end
        cyc(1'b0, 9'd0);
        checks++;
        if ({row0, vact0, vs0} !== {9'd1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL first_line_end got row=%0d vact=%b vs=%b exp row=1 vact=1 vs=1",
                     row0, vact0, vs0);
        end
    endtask

    task automatic test_vsync_band();
        int guard = 0;
        int lows  = 0;
        while (e_row[0] != 9'd273 && guard < 400) begin
            rand_line();
            guard++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ((dv[k] & msk(k)) !== (expv(k) & msk(k))) begin
                    failures++;
                    $display("FAIL walk_to_273 inst%0d got=%h exp=%h", k, dv[k], expv(k));
                end
            end
        end
        checks++;
        if (guard >= 400 || vs0 !== 1'b1 || vact0 !== 1'b0) begin
            failures++;
            $display("FAIL row273 got row=%0d vs=%b vact=%b exp row=273 vs=1 vact=0", row0, vs0, vact0);
        end
        for (int n = 0; n < 12; n++) begin
            rand_line();
            checks++;
            if ({row0, vact0, vs0} !== {e_row[0], e_vact[0], e_vs[0]}) begin
                failures++;
                $display("FAIL vsync_decode got row=%0d vact=%b vs=%b exp row=%0d vact=%b vs=%b",
                         row0, vact0, vs0, e_row[0], e_vact[0], e_vs[0]);
            end
            if (vs0 === 1'b0) lows++;
            if (e_row[0] == 9'd274) begin
                checks++;
                if (vs0 !== 1'b0) begin
                    failures++;
                    $display("FAIL vsync_start got=%b exp=0", vs0);
                end
            end
            if (e_row[0] == 9'd284) begin
                checks++;
                if (vs0 !== 1'b1) begin
                    failures++;
                    $display("FAIL vsync_end got=%b exp=1", vs0);
                end
            end
        end
        checks++;
        if (lows != 10) begin
            failures++;
            $display("FAIL vsync_len got=%0d exp=10", lows);
        end
    endtask

    task automatic test_frame_wrap();
        int fs_seen = 0;
        cyc(1'b1, 9'd0);
        cyc(1'b1, 9'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 9'd0);
            if (fs0 === 1'b1) fs_seen++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ((dv[k] & msk(k)) !== (expv(k) & msk(k))) begin
                    failures++;
                    $display("FAIL frame_wrap_cycle inst%0d got=%h exp=%h", k, dv[k], expv(k));
                end
            end
        end
        checks++;
        if (fs_seen != 1 || row0 !== 9'd0 || fc0 !== 8'd1) begin
            failures++;
            $display("FAIL frame_wrap got fs_cycles=%0d row=%0d fcnt=%0d exp 1 0 1", fs_seen, row0, fc0);
        end
    endtask

    task automatic test_pixels();
        int guard = 0;
        while (e_row[0] != 9'd5 && guard < 400) begin rand_line(); guard++; end
        for (int i = 0; i < 480; i++) begin
            cyc(1'b1, 9'(i));
            checks++;
            if ({de0, px0, py0} !== {1'b1, 9'(i), 9'd5}) begin
                failures++;
                $display("FAIL pixel_sweep i=%0d got de=%b x=%0d y=%0d exp de=1 x=%0d y=5",
                         i, de0, px0, py0, i);
            end
        end
        cyc(1'b0, 9'd0);
        checks++;
        if ({de0, row0} !== {1'b0, 9'd6}) begin
            failures++;
            $display("FAIL de_fall got de=%b row=%0d exp de=0 row=6", de0, row0);
        end
        cyc(1'b0, 9'd0);
        checks++;
        if (py0 !== 9'd6) begin
            failures++;
            $display("FAIL pix_y_follow got=%0d exp=6", py0);
        end
        guard = 0;
        while (e_row[0] != 9'd272 && guard < 400) begin rand_line(); guard++; end
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 9'(i));
            checks++;
            if (de0 !== 1'b0) begin
                failures++;
                $display("FAIL de_blank_row272 i=%0d got=%b exp=0", i, de0);
            end
        end
        cyc(1'b0, 9'd0);
    endtask

    task automatic test_async_reset();
        int guard = 0;
        while (e_row[0] != 9'd150 && guard < 400) begin rand_line(); guard++; end
        for (int i = 0; i < 3; i++) cyc(1'b1, 9'(i + 20));
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (dv[0] !== 39'({9'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 9'd0, 9'd0})) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", dv[0],
                     {9'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 9'd0, 9'd0});
        end
        model_reset();
        @(negedge pxclk);
        rstn = 1'b1;
        cyc(1'b1, 9'd0);
        cyc(1'b1, 9'd1);
        checks++;
        if (row0 !== 9'd0) begin
            failures++;
            $display("FAIL post_reset_hold got=%0d exp=0", row0);
        end
        cyc(1'b0, 9'd0);
        checks++;
        if (row0 !== 9'd1 || (dv[0] & msk(0)) !== (expv(0) & msk(0))) begin
            failures++;
            $display("FAIL post_reset_count got=%h exp=%h", dv[0], expv(0));
        end
    endtask

    task automatic test_frame_cnt_wrap();
        bit seen255 = 0;
        logic [7:0] start = e_fc[1];
        for (int n = 0; n < 2048; n++) begin
            run_line(1, 1);
            if (fc1 === 8'd255) seen255 = 1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ((dv[k] & msk(k)) !== (expv(k) & msk(k))) begin
                    failures++;
                    $display("FAIL frame_cnt_run inst%0d n=%0d got=%h exp=%h", k, n, dv[k], expv(k));
                end
            end
        end
        checks++;
        if (!seen255 || fc1 !== start || fc1 !== 8'd0) begin
            failures++;
            $display("FAIL frame_cnt_wrap got=%0d seen255=%0d exp=0 seen255=1", fc1, seen255);
        end
    endtask

    task automatic test_back_to_back_pulses();
        logic [8:0] exp_r = e_row[0];
        for (int n = 0; n < 20; n++) begin
            cyc(1'b1, 9'd0);
            cyc(1'b0, 9'd0);
            cyc(1'b0, 9'd0);
            exp_r = (exp_r == 9'd285) ? 9'd0 : exp_r + 9'd1;
            checks++;
            if (row0 !== exp_r) begin
                failures++;
                $display("FAIL single_pulse n=%0d got=%0d exp=%0d", n, row0, exp_r);
            end
            checks++;
            if ((dv[1] & msk(1)) !== (expv(1) & msk(1))) begin
                failures++;
                $display("FAIL single_pulse_small n=%0d got=%h exp=%h", n, dv[1], expv(1));
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        hact = 1'b0;
        col  = '0;
        @(negedge pxclk);
        test_reset();
        test_vsync_band();
        test_frame_wrap();
        test_pixels();
        test_async_reset();
        test_frame_cnt_wrap();
        test_back_to_back_pulses();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
